// File: rtl/rv32m_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: funct3 codes,
// FSM state encoding and the two special-case result constants.
package rv32m_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [31:0] INT_MIN  = 32'h8000_0000;
    localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

endpackage

// File: rtl/rv32m_muldiv_if.sv
// Request/response bundle between the core control path and the muldiv unit.
interface rv32m_muldiv_if #(parameter int XLEN = 32);

    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (output start, funct3, op_a, op_b,
                    input  busy, done, result);

    modport slave  (input  start, funct3, op_a, op_b,
                    output busy, done, result);

endinterface

// File: rtl/rv32m_sign_fix.sv
// Final result selection: applies operand signs to the unsigned product,
// quotient and remainder, and substitutes the divide-by-zero and signed
// overflow results.
module rv32m_sign_fix
    import rv32m_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]        funct3,
    input  logic [2*XLEN-1:0] acc,
    input  logic [XLEN-1:0]   mag_a,
    input  logic [XLEN-1:0]   mag_b,
    input  logic              sign_a,
    input  logic              sign_b,
    output logic [XLEN-1:0]   result
);

    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;
    logic              div0;
    logic              ovf;

    // Sign correction and per-funct3 selection. A zero divisor leaves the
    // dividend magnitude in the remainder half, so REM/REMU by zero return
    // op_a without a dedicated path.
    always_comb begin
        prod   = (sign_a ^ sign_b) ? -acc : acc;
        quo    = (sign_a ^ sign_b) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem    = sign_a ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        div0   = (mag_b == '0);
        ovf    = sign_a && sign_b && (mag_a == INT_MIN) && (mag_b == XLEN'(1));
        result = '0;
        case (funct3)
            F3_MUL:                       result = prod[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: result = prod[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:              result = div0 ? ALL_ONES : (ovf ? INT_MIN : quo);
            default:                      result = ovf ? '0 : rem;
        endcase
    end

endmodule

// File: rtl/rv32m_muldiv.sv
// Iterative RV32M unit: one radix-2 shift-add or restoring-subtract step per
// cycle on operand magnitudes, sign fixup in the DONE state.
module rv32m_muldiv
    import rv32m_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int ITER = 32
) (
    input  logic           clk,
    input  logic           RST,
    rv32m_muldiv_if.slave  bus
);

    localparam int CW = $clog2(ITER);

    state_e            state, state_nxt;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     idx;
    logic [2:0]        f3;
    logic              sa, sb;
    logic              a_signed, b_signed;
    logic [XLEN-1:0]   ma, mb;
    logic [2*XLEN-1:0] acc, acc_step;
    logic [XLEN:0]     r_sh, diff;
    logic [XLEN-1:0]   res_fix, res_q;
    logic              done_q;

    // Operand bits are consumed MSB first; ITER == XLEN makes ~cnt the index.
    assign idx = ~cnt;

    // Which operands are treated as signed for the incoming request.
    always_comb begin
        a_signed = 1'b0;
        b_signed = 1'b0;
        case (bus.funct3)
            F3_MULH, F3_DIV, F3_REM: begin
                a_signed = 1'b1;
                b_signed = 1'b1;
            end
            F3_MULHSU: a_signed = 1'b1;
            default: ;
        endcase
    end

    // One iteration. Divide keeps remainder in acc[63:32] and shifts quotient
    // bits into acc[31:0]; the remainder never exceeds the divisor, so a
    // 33-bit difference is enough to detect the borrow.
    always_comb begin
        r_sh     = {acc[2*XLEN-1:XLEN], ma[idx]};
        diff     = r_sh - {1'b0, mb};
        acc_step = acc;
        if (f3[2]) begin
            if (!diff[XLEN]) acc_step = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
            else             acc_step = {r_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
        end else begin
            acc_step = {acc[2*XLEN-2:0], 1'b0} + (mb[idx] ? {{XLEN{1'b0}}, ma} : '0);
        end
    end

    rv32m_sign_fix #(.XLEN(XLEN)) u_sign_fix (
        .funct3 (f3),
        .acc    (acc),
        .mag_a  (ma),
        .mag_b  (mb),
        .sign_a (sa),
        .sign_b (sb),
        .result (res_fix)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state: accept only from IDLE, 32 RUN steps, one DONE cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN:     if (cnt == CW'(ITER - 1)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture, iteration datapath and registered result/done pulse.
    always_ff @(posedge clk) begin
        if (RST) begin
            cnt    <= '0;
            f3     <= '0;
            sa     <= 1'b0;
            sb     <= 1'b0;
            ma     <= '0;
            mb     <= '0;
            acc    <= '0;
            res_q  <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    f3  <= bus.funct3;
                    sa  <= a_signed & bus.op_a[XLEN-1];
                    sb  <= b_signed & bus.op_b[XLEN-1];
                    ma  <= (a_signed && bus.op_a[XLEN-1]) ? -bus.op_a : bus.op_a;
                    mb  <= (b_signed && bus.op_b[XLEN-1]) ? -bus.op_b : bus.op_b;
                    acc <= '0;
                    cnt <= '0;
                end
                RUN: begin
                    acc <= acc_step;
                    cnt <= cnt + CW'(1);
                end
                DONE: begin
                    res_q  <= res_fix;
                    done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // busy covers RUN, DONE and the done pulse cycle itself.
    assign bus.busy   = (state != IDLE) || done_q;
    assign bus.done   = done_q;
    assign bus.result = res_q;

endmodule

// File: tb/tb_rv32m_muldiv.sv
// Directed bench for rv32m_muldiv: latency, arithmetic vectors, special
// cases, ignored starts, operand isolation and mid-operation reset.
module tb_rv32m_muldiv;
    import rv32m_pkg::*;

    logic clk = 1'b0;
    logic RST = 1'b1;
    int   n_pass = 0;
    int   n_chk  = 0;

    always #5 clk = ~clk;

    rv32m_muldiv_if #(.XLEN(32)) bus ();

    rv32m_muldiv #(.XLEN(32), .ITER(32)) dut (
        .clk (clk),
        .RST (RST),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic start_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        bus.funct3 = f3;
        bus.op_a   = a;
        bus.op_b   = b;
        bus.start  = 1'b1;
        @(posedge clk); #1;
        bus.start  = 1'b0;
    endtask

    // Counts cycles after the accept edge until done, bounded at 100.
    task automatic wait_done(input bit poke, output int lat, output int busy_cyc);
        lat = 0;
        busy_cyc = 0;
        while (!bus.done && lat < 100) begin
            if (bus.busy) busy_cyc++;
            if (poke) begin
                bus.start = (lat == 5 || lat == 20);
                if (lat == 5) begin
                    bus.op_a   = 32'h1234_5678;
                    bus.funct3 = F3_DIVU;
                end
            end
            @(posedge clk); #1;
            lat++;
        end
        bus.start = 1'b0;
        if (bus.busy) busy_cyc++;
    endtask

    task automatic count_done(input int cycles, output int seen);
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (bus.done) seen++;
        end
    endtask

    task automatic run(input string tag, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp);
        int lat, bc;
        start_op(f3, a, b);
        wait_done(1'b0, lat, bc);
        chk({tag, " latency"}, 32'(lat), 32'd33);
        chk({tag, " result"}, bus.result, exp);
        @(posedge clk); #1;
        chk({tag, " idle"}, {30'd0, bus.busy, bus.done}, 32'd0);
        chk({tag, " held"}, bus.result, exp);
    endtask

    typedef struct {
        string       tag;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int lat, bc, seen;

        bus.start  = 1'b0;
        bus.funct3 = '0;
        bus.op_a   = '0;
        bus.op_b   = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst busy",   32'(bus.busy), 32'd0);
        chk("rst done",   32'(bus.done), 32'd0);
        chk("rst result", bus.result,    32'd0);
        RST = 1'b0;
        @(posedge clk); #1;

        // Basic multiply with latency and busy width.
        start_op(F3_MUL, 32'd7, 32'd6);
        chk("mul busy rise", 32'(bus.busy), 32'd1);
        wait_done(1'b0, lat, bc);
        chk("mul latency", 32'(lat), 32'd33);
        chk("mul result",  bus.result, 32'h0000_002A);
        @(posedge clk); #1;
        chk("mul busy cycles", 32'(bc), 32'd34);
        chk("mul busy fall",   32'(bus.busy), 32'd0);

        vecs.push_back('{"mulh",    F3_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000});
        vecs.push_back('{"mulhu",   F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE});
        vecs.push_back('{"mulhsu",  F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF});
        vecs.push_back('{"mul neg", F3_MUL,    32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFF1});
        vecs.push_back('{"div",     F3_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD});
        vecs.push_back('{"rem",     F3_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF});
        vecs.push_back('{"divu",    F3_DIVU,   32'd100,       32'd7,         32'd14});
        vecs.push_back('{"remu",    F3_REMU,   32'd100,       32'd7,         32'd2});
        vecs.push_back('{"divu z",  F3_DIVU,   32'd100,       32'd0,         32'hFFFF_FFFF});
        vecs.push_back('{"remu z",  F3_REMU,   32'd100,       32'd0,         32'd100});
        vecs.push_back('{"div z",   F3_DIV,    32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF});
        vecs.push_back('{"rem z",   F3_REM,    32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9});
        vecs.push_back('{"div ovf", F3_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000});
        vecs.push_back('{"rem ovf", F3_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0});
        foreach (vecs[i]) run(vecs[i].tag, vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp);

        // Starts during RUN and operand changes after accept are ignored.
        start_op(F3_MUL, 32'd9, 32'd11);
        wait_done(1'b1, lat, bc);
        chk("hs latency", 32'(lat), 32'd33);
        chk("hs result",  bus.result, 32'd99);
        count_done(40, seen);
        chk("hs extra done", 32'(seen), 32'd0);

        // Reset ten cycles into a divide aborts it.
        start_op(F3_DIVU, 32'd100, 32'd7);
        repeat (9) begin @(posedge clk); #1; end
        RST = 1'b1;
        @(posedge clk); #1;
        RST = 1'b0;
        chk("abort busy",   32'(bus.busy), 32'd0);
        chk("abort done",   32'(bus.done), 32'd0);
        chk("abort result", bus.result,    32'd0);
        count_done(50, seen);
        chk("abort no done", 32'(seen), 32'd0);

        // Reset together with start drops the start.
        bus.funct3 = F3_MUL;
        bus.op_a   = 32'd3;
        bus.op_b   = 32'd5;
        bus.start  = 1'b1;
        RST        = 1'b1;
        @(posedge clk); #1;
        bus.start  = 1'b0;
        RST        = 1'b0;
        @(posedge clk); #1;
        chk("rst+start busy", 32'(bus.busy), 32'd0);

        run("mul after rst", F3_MUL, 32'd3, 32'd5, 32'd15);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
